reaction_arena: RTL and testbench
=================================

Name: reaction_arena

Overview:
Multi-player successor to the single-button reaction core. N players race against one shared stimulus: random arm delay, then a lit phase with a shared BCD timer. Per-player results, false-start flags, persistent per-player best times and a round winner are produced. Sits between io_map (buttons) and layout/graphics (display state, BCD values, colour seed).

Parameters:
N_PLAYERS, 2, number of button channels (1..8)
DIGITS, 6, BCD digits per time value
TICK_DIV, 25000, clock cycles per timer tick (>=2)
MIN_WAIT, 500, minimum arm delay in ticks (>=1)
WAIT_MASK, 16'h0FFF, mask on LFSR for extra random arm delay
HOLD_TICKS, 2000, result display hold in ticks (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_btn  in  N_PLAYERS  synchronised, debounced buttons, one per player
i_clr_best  in  1  synchronous clear of all best times
o_lit  out  1  stimulus lamp, high in LIT only
o_dst  out  3  display state: 0 IDLE, 1 ARMED, 2 LIT, 3 RESULT
o_miss  out  N_PLAYERS  per-player false start or timeout in current round
o_done  out  N_PLAYERS  per-player result final for current round
o_measured  out  N_PLAYERS x 4*DIGITS  per-player BCD reaction time
o_best  out  N_PLAYERS x 4*DIGITS  per-player best BCD time
o_winner  out  max(1,$clog2(N_PLAYERS))  winning player index
o_winner_valid  out  1  at least one valid result this round
o_round_done  out  1  one-cycle pulse on entry to RESULT
o_shrnd  out  6  colour seed, latched each round start

Behaviour:
- Reset: state IDLE, o_dst=0, o_lit=0, o_miss=0, o_done=0, o_measured all digits 0, o_best all digits 4'hF (sentinel), o_winner=0, o_winner_valid=0, o_round_done=0, o_shrnd=0, LFSR=16'hACE1, prescaler=0, timer=0.
- LFSR: 16-bit Galois, taps 16,14,13,11, advances every cycle incl. all states; never zero.
- Button events: rising edge only (registered previous value, reset 0). Button held across a state change is not an event.
- Prescaler counts 0..TICK_DIV-1 in ARMED, LIT, RESULT; tick=1 at TICK_DIV-1; cleared to 0 on every state transition.
- IDLE: any event -> ARMED next cycle; same cycle: wait <= MIN_WAIT + (LFSR & WAIT_MASK), o_shrnd <= LFSR[5:0], o_miss/o_done <= 0, o_measured <= 0, timer <= 0, o_winner_valid <= 0.
- ARMED: wait decrements per tick; event from player i with !o_done[i] sets o_miss[i], o_done[i]. Event in the same cycle as wait reaching 0 is a false start. All done -> RESULT. Wait reaches 0 with players remaining -> LIT.
- LIT: BCD timer increments per tick (per-digit carry, decimal). Event from player i with !o_done[i]: o_measured[i] <= timer value registered in that cycle (pre-increment), o_done[i] <= 1. Simultaneous events get identical times. All done -> RESULT. Timer at all-9s with tick: remaining players get o_miss=1, o_done=1, o_measured=all 4'hF; -> RESULT. Event in the saturating cycle is recorded as a result, not a miss.
- Entry to RESULT: o_round_done=1 for exactly one cycle. Same cycle: for each i with !o_miss[i] and measured < best: best <= measured (plain unsigned compare; valid for BCD). Winner = lowest measured among non-missed, ties -> lowest index; none -> o_winner_valid=0, o_winner=0. All outputs final on the cycle after the pulse.
- RESULT: held HOLD_TICKS ticks, then -> IDLE; events ignored.
- i_clr_best: best <= sentinel next cycle; wins over same-cycle best update.
- Reset mid-round: immediate return to reset values; best times are lost.

Decomposition:
- Package r0_pkg: dst_e enum (IDLE/ARMED/LIT/RESULT, 3 bits), BCD_SENTINEL digit 4'hF, LFSR_SEED, LFSR_TAPS.
- Sub-module bcd_counter (param DIGITS; i_clk, i_rst, i_clr, i_inc, o_value, o_max). Decimal ripple carry, holds at all-9s.
- Winner selection as a combinational loop inside reaction_arena.

Test Plan:
- Config TICK_DIV=4, MIN_WAIT=3, WAIT_MASK=0, HOLD_TICKS=2, N=2. P0 press -> ARMED for exactly 12 cycles -> LIT. Then P1 press after 5 ticks, P0 after 7 -> measured {7,5}, winner=1, valid=1, single round_done pulse, best {7,5}.
- P0 presses during ARMED -> miss[0]=1 immediately, round continues. P1 presses at tick 3 -> winner=1, best[0] unchanged (sentinel).
- Both press in ARMED -> RESULT without LIT, winner_valid=0. Both press same cycle in LIT at tick 4 -> both measured 4, winner=0 (tie to lowest index).
- DIGITS=2: no press in LIT -> timer reaches 99, miss=2'b11, measured all 4'hF, winner_valid=0. Press in saturation cycle -> measured 99, no miss.
- Second round times {9,3} after {7,5} -> best {7,3}. i_clr_best -> best all 4'hF. Clear together with update -> sentinel.
- Assert i_rst mid-LIT -> all outputs at reset values the same cycle, asynchronously. Button held through reset release -> no event until release and re-press.

Source files
------------

// File: rtl/r0_pkg.sv
// r0_pkg: shared display states and constants for reaction_arena
package r0_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, LIT = 3'd2, RESULT = 3'd3} dst_e;
  localparam logic [3:0] BCD_SENTINEL = 4'hF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: decimal ripple-carry counter that saturates at all nines
module bcd_counter #(
  parameter int DIGITS = 6
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_max
);
  logic [4*DIGITS-1:0] nxt;
  logic cy;
  assign o_max = o_value == {DIGITS{4'h9}};
  // ripple a decimal carry from the least significant digit upward
  always_comb begin
    nxt = o_value;
    cy = i_inc && !o_max;
    for (int d = 0; d < DIGITS; d++) begin
      nxt[4*d+:4] = cy ? (o_value[4*d+:4] == 4'h9 ? 4'h0 : o_value[4*d+:4] + 4'h1) : o_value[4*d+:4];
      cy = cy && o_value[4*d+:4] == 4'h9;
    end
  end
  // counter register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_value <= '0;
    else o_value <= i_clr ? '0 : nxt;
endmodule

// File: rtl/reaction_arena.sv
// reaction_arena: multi-player reaction race with shared BCD timer, best times and winner
module reaction_arena
  import r0_pkg::*;
#(
  parameter int          N_PLAYERS  = 2,
  parameter int          DIGITS     = 6,
  parameter int          TICK_DIV   = 25000,
  parameter int          MIN_WAIT   = 500,
  parameter logic [15:0] WAIT_MASK  = 16'h0FFF,
  parameter int          HOLD_TICKS = 2000,
  localparam int         NW = N_PLAYERS > 1 ? $clog2(N_PLAYERS) : 1,
  localparam int         TW = 4 * DIGITS
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_PLAYERS-1:0]           i_btn,
  input  logic                           i_clr_best,
  output logic                           o_lit,
  output logic [2:0]                     o_dst,
  output logic [N_PLAYERS-1:0]           o_miss,
  output logic [N_PLAYERS-1:0]           o_done,
  output logic [N_PLAYERS-1:0][TW-1:0]   o_measured,
  output logic [N_PLAYERS-1:0][TW-1:0]   o_best,
  output logic [NW-1:0]                  o_winner,
  output logic                           o_winner_valid,
  output logic                           o_round_done,
  output logic [5:0]                     o_shrnd
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int WW = $clog2(MIN_WAIT + 65536 + HOLD_TICKS);
  dst_e state, nxt;
  logic [15:0] lfsr;
  logic [N_PLAYERS-1:0] btn_q, ev, hit, done_n;
  logic live, tick, wait_end, sat, t_max, w_ok;
  logic [PW-1:0] presc;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] t_val, w_t;
  logic [NW-1:0] w_idx;
  // live masks the first cycle after reset so a button held through reset is not an edge
  assign ev = i_btn & ~btn_q & {N_PLAYERS{live}};
  assign hit = ev & ~o_done;
  assign done_n = o_done | hit;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign wait_end = tick && wait_cnt == WW'(1);
  assign sat = tick && t_max;
  assign o_dst = state;
  assign o_lit = state == LIT;
  bcd_counter #(.DIGITS(DIGITS)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state == IDLE && |ev),
    .i_inc  (state == LIT && tick),
    .o_value(t_val),
    .o_max  (t_max)
  );
  // next display state
  always_comb
    nxt = state == IDLE  ? (|ev ? ARMED : IDLE)
        : state == ARMED ? (&done_n ? RESULT : wait_end ? LIT : ARMED)
        : state == LIT   ? (&done_n || sat ? RESULT : LIT)
        : (wait_end ? IDLE : RESULT);
  // lowest time among non-missed players, ties resolved to the lowest index
  always_comb begin
    w_ok = 1'b0;
    w_idx = '0;
    w_t = '1;
    for (int i = 0; i < N_PLAYERS; i++)
      if (!o_miss[i] && (!w_ok || o_measured[i] < w_t)) begin
        w_ok = 1'b1;
        w_idx = NW'(i);
        w_t = o_measured[i];
      end
  end
  // round sequencing, per-player results and best-time bookkeeping
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      btn_q <= '0;
      live <= 1'b0;
      presc <= '0;
      wait_cnt <= '0;
      o_miss <= '0;
      o_done <= '0;
      o_measured <= '0;
      o_best <= {N_PLAYERS{{DIGITS{BCD_SENTINEL}}}};
      o_winner <= '0;
      o_winner_valid <= 1'b0;
      o_round_done <= 1'b0;
      o_shrnd <= '0;
    end else begin
      state <= nxt;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
      btn_q <= i_btn;
      live <= 1'b1;
      presc <= (state == IDLE || nxt != state || tick) ? '0 : presc + 1'b1;
      o_round_done <= nxt == RESULT && state != RESULT;
      wait_cnt <= state == IDLE ? WW'(MIN_WAIT) + WW'(lfsr & WAIT_MASK)
                : nxt == RESULT && state != RESULT ? WW'(HOLD_TICKS)
                : tick ? wait_cnt - 1'b1 : wait_cnt;
      if (state == IDLE && |ev) begin
        o_shrnd <= lfsr[5:0];
        o_miss <= '0;
        o_done <= '0;
        o_measured <= '0;
        o_winner_valid <= 1'b0;
      end
      if (state == ARMED) begin
        o_miss <= o_miss | hit;
        o_done <= done_n;
      end
      if (state == LIT) begin
        o_done <= sat ? '1 : done_n;
        o_miss <= sat ? o_miss | ~done_n : o_miss;
        for (int i = 0; i < N_PLAYERS; i++)
          o_measured[i] <= hit[i] ? t_val : sat && !done_n[i] ? '1 : o_measured[i];
      end
      if (o_round_done) begin
        o_winner <= w_idx;
        o_winner_valid <= w_ok;
        for (int i = 0; i < N_PLAYERS; i++)
          if (!o_miss[i] && o_measured[i] < o_best[i]) o_best[i] <= o_measured[i];
      end
      if (i_clr_best) o_best <= {N_PLAYERS{{DIGITS{BCD_SENTINEL}}}};
    end
endmodule

// File: tb/tb_reaction_arena.sv
// tb_reaction_arena: directed rounds against hand-computed times, winners and best values
module tb_reaction_arena;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, lit, wv, rd;
  logic [1:0] btn = 2'b00, miss, done;
  logic [2:0] dst;
  logic [1:0][7:0] measured, best;
  logic [0:0] winner;
  logic [5:0] shrnd, shr_exp;
  logic [15:0] m_lfsr;
  int n_tests = 0, n_fail = 0;

  reaction_arena #(
    .N_PLAYERS(2), .DIGITS(2), .TICK_DIV(4), .MIN_WAIT(3), .WAIT_MASK(16'h0000), .HOLD_TICKS(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_clr_best(clr),
    .o_lit(lit), .o_dst(dst), .o_miss(miss), .o_done(done),
    .o_measured(measured), .o_best(best), .o_winner(winner),
    .o_winner_valid(wv), .o_round_done(rd), .o_shrnd(shrnd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    m_lfsr <= rst ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] m);
    btn = m;
    shr_exp = m_lfsr[5:0];
    @(negedge clk);
    btn = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_dst", dst, 0);
    check("rst_lit", lit, 0);
    check("rst_best", best, 16'hFFFF);
    check("rst_meas", measured, 16'h0000);
    check("rst_shrnd", shrnd, 0);
    rst = 1'b0;
    step(2);
    // round a: P1 at tick 5, P0 at tick 7
    press(2'b01);
    check("a_armed", dst, 1);
    check("a_shrnd", shrnd, shr_exp);
    step(11);
    check("a_armed_c12", dst, 1);
    step(1);
    check("a_lit", dst, 2);
    check("a_lamp", lit, 1);
    step(20); press(2'b10);
    step(7); press(2'b01);
    check("a_rd_pulse", rd, 1);
    check("a_result", dst, 3);
    step(1);
    check("a_rd_single", rd, 0);
    check("a_meas", measured, 16'h0507);
    check("a_win", winner, 1);
    check("a_wv", wv, 1);
    check("a_best", best, 16'h0507);
    step(6);
    check("a_hold", dst, 3);
    step(1);
    check("a_idle", dst, 0);
    // round b: P1 at tick 3, P0 at tick 9
    press(2'b01);
    step(12); step(12); press(2'b10);
    step(23); press(2'b01);
    step(1);
    check("b_meas", measured, 16'h0309);
    check("b_win", winner, 1);
    check("b_best", best, 16'h0307);
    step(7);
    check("b_idle", dst, 0);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_best", best, 16'hFFFF);
    // round c: P0 false start, P1 at tick 3
    press(2'b01);
    step(2); press(2'b01);
    check("c_miss", miss, 2'b01);
    check("c_done", done, 2'b01);
    check("c_armed", dst, 1);
    step(8); step(1);
    check("c_lit", lit, 1);
    step(12); press(2'b10);
    step(1);
    check("c_win", winner, 1);
    check("c_wv", wv, 1);
    check("c_best", best, 16'h03FF);
    step(7);
    check("c_idle", dst, 0);
    // round d: both false start
    press(2'b01);
    step(1); press(2'b11);
    check("d_result", dst, 3);
    check("d_rd", rd, 1);
    step(1);
    check("d_wv", wv, 0);
    check("d_win", winner, 0);
    check("d_miss", miss, 2'b11);
    step(7);
    check("d_idle", dst, 0);
    // round e: tie at tick 4, clear coincides with best update
    press(2'b01);
    step(12); step(16); press(2'b11);
    clr = 1'b1; step(1); clr = 1'b0;
    check("e_meas", measured, 16'h0404);
    check("e_win", winner, 0);
    check("e_wv", wv, 1);
    check("e_best", best, 16'hFFFF);
    step(7);
    check("e_idle", dst, 0);
    // round f: nobody presses, timer saturates at 99
    press(2'b01);
    step(12); step(399);
    check("f_lit_l400", dst, 2);
    step(1);
    check("f_result", dst, 3);
    step(1);
    check("f_miss", miss, 2'b11);
    check("f_done", done, 2'b11);
    check("f_meas", measured, 16'hFFFF);
    check("f_wv", wv, 0);
    step(7);
    check("f_idle", dst, 0);
    // round g: P0 presses in the saturating cycle
    press(2'b01);
    step(12); step(399); press(2'b01);
    step(1);
    check("g_meas", measured, 16'hFF99);
    check("g_miss", miss, 2'b10);
    check("g_win", winner, 0);
    check("g_wv", wv, 1);
    check("g_best", best, 16'hFF99);
    step(7);
    check("g_idle", dst, 0);
    // round h: asynchronous reset mid-LIT with a held button
    press(2'b01);
    check("h_shrnd", shrnd, shr_exp);
    step(12); step(5);
    btn = 2'b01;
    step(1);
    #2 rst = 1'b1;
    #1;
    check("h_rst_dst", dst, 0);
    check("h_rst_lit", lit, 0);
    check("h_rst_best", best, 16'hFFFF);
    check("h_rst_meas", measured, 16'h0000);
    check("h_rst_done", done, 0);
    check("h_rst_shrnd", shrnd, 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("h_held", dst, 0);
    btn = 2'b00;
    step(2);
    press(2'b01);
    check("h_repress", dst, 1);
    check("h_shrnd2", shrnd, shr_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
